// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg
//   Shared definitions for the UART transmit arbiter.
//   - arb_state_t : 3-bit arbiter state encoding (ARB_IDLE .. ARB_DONE)
//   - GRANT_W     : width of the grant / winner index (supports up to 8 requesters)
//   - CNT_W       : width of the busy-timeout counter
package uart_tx_arbiter_pkg;

  localparam int GRANT_W = 3;
  localparam int CNT_W   = 5;

  typedef enum logic [2:0] {
    ARB_IDLE      = 3'd0,
    ARB_START     = 3'd1,
    ARB_WAIT_BUSY = 3'd2,
    ARB_SENDING   = 3'd3,
    ARB_DONE      = 3'd4
  } arb_state_t;

endpackage

// File: rtl/uart_arb_pick.sv
// uart_arb_pick
//   Purely combinational winner selection for the UART transmit arbiter.
//   Ports:
//     pending   in  N_REQ   requesters holding a byte
//     last      in  3       previous winner (round-robin pointer)
//     fixed_pri in  1       1: lowest index wins, 0: round-robin from last+1
//     winner    out 3       selected requester index
//     valid     out 1       at least one requester is pending
module uart_arb_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]   pending,
  input  logic [GRANT_W-1:0] last,
  input  logic               fixed_pri,
  output logic [GRANT_W-1:0] winner,
  output logic               valid
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Scan candidates from lowest to highest priority so the highest-priority hit is written last
  always_comb begin
    winner = '0;
    valid  = |pending;
    if (fixed_pri) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        winner = pending[IW'(i)] ? GRANT_W'(i) : winner;
      end
    end else begin
      for (int off = N_REQ; off >= 1; off--) begin
        winner = pending[IW'((int'(last) + off) % N_REQ)] ?
                 GRANT_W'((int'(last) + off) % N_REQ) : winner;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_transmit instance between N_REQ byte producers. Each producer
//   posts a byte with a one-cycle strobe; the byte is held until it has been sent.
//   Build option: define UART_ARB_FIXED_PRI_EN for fixed priority (lowest index
//   wins); otherwise winners are chosen round-robin starting after the last grant.
//   Ports:
//     clk, rst   in   clock, synchronous active-high reset
//     req        in   N_REQ         per-requester post strobe
//     req_data   in   N_REQ*DATA_W  byte of requester i at [i*DATA_W +: DATA_W]
//     pending    out  N_REQ         requester has a held byte not yet completed
//     done       out  N_REQ         one-cycle pulse when a byte finished on the line
//     overflow   out  N_REQ         sticky: post arrived while still pending
//     ovf_clr    in   1             clear all overflow bits
//     tx_send    out  1             start strobe to uart_transmit
//     tx_data    out  DATA_W        byte to uart_transmit, stable START..DONE
//     tx_ready   in   1             ready from uart_transmit
//     busy       out  1             sequencer not idle
//     grant      out  3             current or last winner
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        pending,
  output logic [N_REQ-1:0]        done,
  output logic [N_REQ-1:0]        overflow,
  input  logic                    ovf_clr,
  output logic                    tx_send,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic [GRANT_W-1:0]      grant
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(BUSY_TIMEOUT);

`ifdef UART_ARB_FIXED_PRI_EN
  localparam logic FIXED_PRI = 1'b1;
`else
  localparam logic FIXED_PRI = 1'b0;
`endif

  arb_state_t         state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [DATA_W-1:0]  hold_r [N_REQ];
  logic [DATA_W-1:0]  req_byte_s [N_REQ];
  logic [DATA_W-1:0]  sel_byte_s;
  logic [N_REQ-1:0]   grant_onehot_s;
  logic [GRANT_W-1:0] winner_s;
  logic               valid_s;

  for (genvar g = 0; g < N_REQ; g++) begin : g_req_byte
    assign req_byte_s[g] = req_data[g*DATA_W +: DATA_W];
  end

  uart_arb_pick #(.N_REQ(N_REQ)) u_pick (
    .pending   (pending),
    .last      (grant),
    .fixed_pri (FIXED_PRI),
    .winner    (winner_s),
    .valid     (valid_s)
  );

  // Mux the winner's held byte and decode the grant to a one-hot done vector
  always_comb begin
    sel_byte_s     = '0;
    grant_onehot_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_byte_s        = (winner_s == GRANT_W'(i)) ? hold_r[IW'(i)] : sel_byte_s;
      grant_onehot_s[IW'(i)] = (grant == GRANT_W'(i));
    end
  end

  // Holding registers, pending flags and sticky overflow per requester
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      overflow <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        hold_r[IW'(i)] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        // A repost in the done cycle refills the slot instead of overflowing.
        if (req[IW'(i)] && (!pending[IW'(i)] || done[IW'(i)])) begin
          hold_r[IW'(i)]  <= req_byte_s[IW'(i)];
          pending[IW'(i)] <= 1'b1;
        end else if (done[IW'(i)]) begin
          pending[IW'(i)] <= 1'b0;
        end
        // A new overflow event takes precedence over a simultaneous clear.
        if (req[IW'(i)] && pending[IW'(i)] && !done[IW'(i)]) begin
          overflow[IW'(i)] <= 1'b1;
        end else if (ovf_clr) begin
          overflow[IW'(i)] <= 1'b0;
        end
      end
    end
  end

  // Arbitration and send/ready handshake sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ARB_IDLE;
      cnt_r   <= '0;
      tx_send <= 1'b0;
      tx_data <= '0;
      done    <= '0;
      busy    <= 1'b0;
      grant   <= GRANT_W'(N_REQ - 1);
    end else begin
      tx_send <= 1'b0;
      done    <= '0;
      case (state_r)
        ARB_IDLE: begin
          if (valid_s && tx_ready) begin
            grant   <= winner_s;
            tx_data <= sel_byte_s;
            tx_send <= 1'b1;
            cnt_r   <= '0;
            busy    <= 1'b1;
            state_r <= ARB_START;
          end
        end
        ARB_START: begin
          state_r <= ARB_WAIT_BUSY;
        end
        ARB_WAIT_BUSY: begin
          if (!tx_ready) begin
            state_r <= ARB_SENDING;
          end else if (cnt_r == TO_LAST) begin
            // The UART never acknowledged the strobe; issue it again.
            tx_send <= 1'b1;
            cnt_r   <= '0;
            state_r <= ARB_START;
          end else if (cnt_r < TO_MAX) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ARB_SENDING: begin
          if (tx_ready) begin
            done    <= grant_onehot_s;
            state_r <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          busy    <= 1'b0;
          state_r <= ARB_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
